// File: rtl/axis_pkt_monitor_if.sv
// rtl/axis_pkt_monitor_if.sv - byte stream in and per-packet status record out of axis_pkt_monitor
interface axis_pkt_monitor_if #(
    parameter int LEN_W = 7
);
    logic [7:0]       s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic             stat_valid;
    logic             stat_ready;
    logic [LEN_W-1:0] stat_len;
    logic [15:0]      stat_sum;
    logic             stat_err;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, stat_ready,
        output stat_valid, stat_len, stat_sum, stat_err
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, stat_ready,
        input  stat_valid, stat_len, stat_sum, stat_err
    );
endinterface

// File: rtl/axis_pkt_monitor.sv
// rtl/axis_pkt_monitor.sv - per-packet length/sum/oversize accounting with a one-deep status register
module axis_pkt_monitor #(
    parameter int MAX_LEN = 64,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                aclk,
    input  logic                areset,
    axis_pkt_monitor_if.slave   s,
    output logic                busy,
    output logic [15:0]         pkt_cnt,
    output logic [7:0]          drop_cnt
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        OVERSIZE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      sum_q, sum_d;

    // Record as it would look including the current beat.
    logic [LEN_W-1:0] rec_len;
    logic [15:0]      rec_sum;
    logic             rec_err;

    logic             stat_valid_q;
    logic [LEN_W-1:0] stat_len_q;
    logic [15:0]      stat_sum_q;
    logic             stat_err_q;

    logic             beat, complete, pop, load;

    assign beat     = s.s_tvalid;
    assign complete = s.s_tvalid & s.s_tlast;
    assign pop      = stat_valid_q & s.stat_ready;
    assign load     = complete & (~stat_valid_q | pop);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            len_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rec_len = len_q;
        rec_sum = sum_q;
        rec_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                rec_len = LEN_W'(1);
                rec_sum = {8'h00, s.s_tdata};
                if (beat && !s.s_tlast) state_d = ACTIVE;
            end
            ACTIVE: begin
                // A full packet does not count or sum the extra byte; it only marks the error.
                if (len_q == LEN_W'(MAX_LEN)) begin
                    rec_err = 1'b1;
                    if (beat) state_d = OVERSIZE;
                end else begin
                    rec_len = len_q + LEN_W'(1);
                    rec_sum = sum_q + {8'h00, s.s_tdata};
                end
            end
            OVERSIZE: begin
                rec_err = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (complete) state_d = IDLE;

        len_d = len_q;
        sum_d = sum_q;
        if (complete) begin
            len_d = '0;
            sum_d = '0;
        end else if (beat) begin
            len_d = rec_len;
            sum_d = rec_sum;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_valid_q <= 1'b0;
            stat_len_q   <= '0;
            stat_sum_q   <= '0;
            stat_err_q   <= 1'b0;
            pkt_cnt      <= '0;
            drop_cnt     <= '0;
        end else begin
            if (load) begin
                stat_valid_q <= 1'b1;
                stat_len_q   <= rec_len;
                stat_sum_q   <= rec_sum;
                stat_err_q   <= rec_err;
            end else if (pop) begin
                stat_valid_q <= 1'b0;
            end
            if (complete) begin
                pkt_cnt <= pkt_cnt + 16'd1;
                if (!load && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign s.stat_valid = stat_valid_q;
    assign s.stat_len   = stat_len_q;
    assign s.stat_sum   = stat_sum_q;
    assign s.stat_err   = stat_err_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_axis_pkt_monitor.sv
// tb/tb_axis_pkt_monitor.sv - directed table-driven bench for axis_pkt_monitor
module tb_axis_pkt_monitor;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;

    logic        aclk = 1'b0;
    logic        areset;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    axis_pkt_monitor_if #(.LEN_W(LEN_W)) bus ();

    axis_pkt_monitor #(.MAX_LEN(MAX_LEN)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s        (bus.slave),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic             v;
        logic             l;
        logic [7:0]       d;
        logic             r;
        logic             ev;
        logic [LEN_W-1:0] len;
        logic [15:0]      sum;
        logic             err;
        logic             bsy;
        logic [15:0]      pkt;
        logic [7:0]       drop;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record fields are only meaningful while stat_valid is expected high.
    task automatic chk_all(input string tag, input logic ev, input logic [LEN_W-1:0] len,
                           input logic [15:0] sum, input logic err, input logic bsy,
                           input logic [15:0] pkt, input logic [7:0] drop);
        chk({tag, ".valid"}, 32'(bus.stat_valid), 32'(ev));
        chk({tag, ".busy"},  32'(busy),           32'(bsy));
        chk({tag, ".pkt"},   32'(pkt_cnt),        32'(pkt));
        chk({tag, ".drop"},  32'(drop_cnt),       32'(drop));
        if (ev) begin
            chk({tag, ".len"}, 32'(bus.stat_len), 32'(len));
            chk({tag, ".sum"}, 32'(bus.stat_sum), 32'(sum));
            chk({tag, ".err"}, 32'(bus.stat_err), 32'(err));
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [7:0] d, input logic r);
        bus.s_tvalid   = v;
        bus.s_tlast    = l;
        bus.s_tdata    = d;
        bus.stat_ready = r;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // basic packet
        vecs[0]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 16'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 16'd0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 16'd0, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 7'd4, 16'h000A, 1'b0, 1'b0, 16'd1, 8'd0};
        // single-beat packet, popped and reloaded on the same edge
        vecs[4]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 7'd1, 16'h00FF, 1'b0, 1'b0, 16'd2, 8'd0};
        // bubbles
        vecs[5]  = '{1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 16'd2, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 16'd2, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 16'd2, 8'd0};
        vecs[8]  = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 16'd2, 8'd0};
        vecs[9]  = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 16'd2, 8'd0};
        vecs[10] = '{1'b1, 1'b1, 8'h30, 1'b1, 1'b1, 7'd3, 16'h0060, 1'b0, 1'b0, 16'd3, 8'd0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 16'd3, 8'd0};
        // backpressure: first record held, second dropped
        vecs[12] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 16'd3, 8'd0};
        vecs[13] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 7'd2, 16'h0033, 1'b0, 1'b0, 16'd4, 8'd0};
        vecs[14] = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 7'd2, 16'h0033, 1'b0, 1'b1, 16'd4, 8'd0};
        vecs[15] = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 7'd2, 16'h0033, 1'b0, 1'b0, 16'd5, 8'd1};
        // third packet completes together with a pop
        vecs[16] = '{1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 7'd2, 16'h0033, 1'b0, 1'b1, 16'd5, 8'd1};
        vecs[17] = '{1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 7'd2, 16'h000C, 1'b0, 1'b0, 16'd6, 8'd1};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 16'd6, 8'd1};

        areset         = 1'b1;
        bus.s_tvalid   = 1'b1;
        bus.s_tlast    = 1'b1;
        bus.s_tdata    = 8'h5A;
        bus.stat_ready = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        chk_all("reset", 1'b0, '0, '0, 1'b0, 1'b0, 16'd0, 8'd0);
        chk("reset.len", 32'(bus.stat_len), 32'd0);
        chk("reset.sum", 32'(bus.stat_sum), 32'd0);
        chk("reset.err", 32'(bus.stat_err), 32'd0);
        areset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].r);
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].len, vecs[i].sum,
                    vecs[i].err, vecs[i].bsy, vecs[i].pkt, vecs[i].drop);
        end

        // oversize: 70 beats of 0x01
        for (int i = 1; i <= 70; i++) begin
            drive(1'b1, (i == 70), 8'h01, 1'b1);
            if (i == 64 || i == 65 || i == 69)
                chk_all($sformatf("over_b%0d", i), 1'b0, '0, '0, 1'b0, 1'b1, 16'd6, 8'd1);
        end
        chk_all("over_end", 1'b1, 7'd64, 16'h0040, 1'b1, 1'b0, 16'd7, 8'd1);
        drive(1'b1, 1'b0, 8'h01, 1'b1);
        drive(1'b1, 1'b1, 8'h02, 1'b1);
        chk_all("after_over", 1'b1, 7'd2, 16'h0003, 1'b0, 1'b0, 16'd8, 8'd1);

        // exactly MAX_LEN bytes is legal
        for (int i = 1; i <= 64; i++) drive(1'b1, (i == 64), 8'h02, 1'b1);
        chk_all("exact_max", 1'b1, 7'd64, 16'h0080, 1'b0, 1'b0, 16'd9, 8'd1);

        // MAX_LEN+1 with tlast on the extra beat
        for (int i = 1; i <= 65; i++) drive(1'b1, (i == 65), 8'h03, 1'b1);
        chk_all("max_plus1", 1'b1, 7'd64, 16'h00C0, 1'b1, 1'b0, 16'd10, 8'd1);

        // reset mid-packet with a pending record
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h09, 1'b0);
        chk_all("pre_reset", 1'b1, 7'd64, 16'h00C0, 1'b1, 1'b1, 16'd10, 8'd1);
        areset = 1'b1;
        drive(1'b1, 1'b1, 8'h77, 1'b0);
        chk_all("mid_reset", 1'b0, '0, '0, 1'b0, 1'b0, 16'd0, 8'd0);
        chk("mid_reset.len", 32'(bus.stat_len), 32'd0);
        chk("mid_reset.sum", 32'(bus.stat_sum), 32'd0);
        areset = 1'b0;
        drive(1'b1, 1'b0, 8'h05, 1'b1);
        drive(1'b1, 1'b1, 8'h06, 1'b1);
        chk_all("post_reset", 1'b1, 7'd2, 16'h000B, 1'b0, 1'b0, 16'd1, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
